// File: rtl/remote_pkg.sv
// Shared key codes and control states for the TV command unit.
// Used by tv_command_unit and its timer sub-module.
package remote_pkg;

  localparam logic [7:0] KEY_DIGIT_MAX = 8'h09;
  localparam logic [7:0] KEY_CH_UP     = 8'h10;
  localparam logic [7:0] KEY_CH_DOWN   = 8'h11;
  localparam logic [7:0] KEY_VOL_UP    = 8'h20;
  localparam logic [7:0] KEY_VOL_DOWN  = 8'h21;
  localparam logic [7:0] KEY_MUTE      = 8'h30;
  localparam logic [7:0] KEY_POWER     = 8'h40;

  typedef enum logic [1:0] {
    OFF,
    IDLE,
    DIGIT1
  } state_e;

  function automatic logic is_digit(input logic [7:0] k);
    return k <= KEY_DIGIT_MAX;
  endfunction

  function automatic logic is_known(input logic [7:0] k);
    return is_digit(k)
        || k == KEY_CH_UP    || k == KEY_CH_DOWN
        || k == KEY_VOL_UP   || k == KEY_VOL_DOWN
        || k == KEY_MUTE     || k == KEY_POWER;
  endfunction

endpackage

// File: rtl/tv_command_unit_cycle_timer.sv
// Loadable down-counter; o_expired is high during the cycle in which
// the count steps from 1 to 0, so it is seen exactly MAX cycles after load.
module cycle_timer #(
  parameter int unsigned MAX = 1,
  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_clear,
  output logic o_expired
);

  logic [W-1:0] r_cnt;

  // load has priority over clear; otherwise count down to zero and stop
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(MAX);
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = (r_cnt == W'(1));

endmodule

// File: rtl/tv_command_unit.sv
// TV command unit: remote key codes -> power/channel/volume/mute state.
// Optional macro REMOTE_HOLDOFF_EN filters repeats of the same key.
module tv_command_unit
  import remote_pkg::*;
#(
  parameter int unsigned CH_MIN         = 1,
  parameter int unsigned CH_MAX         = 99,
  parameter int unsigned VOL_MAX        = 63,
  parameter int unsigned VOL_INIT       = 16,
  parameter int unsigned DIGIT_TIMEOUT  = 1000,
  parameter int unsigned HOLDOFF_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready,
  input  logic [7:0] remote_key,
  output logic       power_on,
  output logic [6:0] channel,
  output logic [5:0] volume,
  output logic       mute,
  output logic       digit_pending,
  output logic       cmd_valid
);

  state_e     r_state;
  logic       r_ready_d;
  logic       r_key_v;
  logic [7:0] r_key;
  logic [3:0] r_digit;
  logic       r_power;
  logic [6:0] r_chan;
  logic [5:0] r_vol;
  logic       r_mute;
  logic       r_pend;
  logic       r_cmd;

  logic       w_go;
  logic       w_known;
  logic       w_is_dig;
  logic       w_hold_blk;
  logic       w_dig_load;
  logic       w_dig_clr;
  logic       w_dig_exp;
  logic [6:0] w_two;
  logic [6:0] w_one;
  logic       w_two_ok;
  logic       w_one_ok;

  // capture one key per rising edge of ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready_d <= 1'b0;
      r_key_v   <= 1'b0;
      r_key     <= '0;
    end else begin
      r_ready_d <= ready;
      r_key_v   <= ready & ~r_ready_d;
      if (ready & ~r_ready_d) r_key <= remote_key;
    end
  end

  assign w_go     = r_key_v & ~w_hold_blk;
  assign w_known  = is_known(r_key);
  assign w_is_dig = is_digit(r_key);
  assign w_two    = 7'(r_digit) * 7'd10 + 7'(r_key[3:0]);
  assign w_one    = 7'(r_digit);
  assign w_two_ok = (w_two >= 7'(CH_MIN)) && (w_two <= 7'(CH_MAX));
  assign w_one_ok = (w_one >= 7'(CH_MIN)) && (w_one <= 7'(CH_MAX));

  assign w_dig_load = w_go && w_is_dig && (r_state == IDLE);
  assign w_dig_clr  = (r_state == DIGIT1) && ((w_go && w_known) || w_dig_exp);

  cycle_timer #(.MAX(DIGIT_TIMEOUT)) u_digit_timer (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_load    (w_dig_load),
    .i_clear   (w_dig_clr),
    .o_expired (w_dig_exp)
  );

`ifdef REMOTE_HOLDOFF_EN
  logic [7:0] r_last_key;
  logic       r_hold_win;
  logic       w_hold_exp;
  logic       w_acc;

  assign w_hold_blk = r_hold_win && (r_key == r_last_key);
  assign w_acc      = w_go && w_known
                   && ((r_state != OFF) || (r_key == KEY_POWER));

  cycle_timer #(.MAX(HOLDOFF_CYCLES)) u_hold_timer (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_load    (w_acc),
    .i_clear   (1'b0),
    .o_expired (w_hold_exp)
  );

  // remember the last accepted key while its repeat window is open
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_key <= '0;
      r_hold_win <= 1'b0;
    end else if (w_acc) begin
      r_last_key <= r_key;
      r_hold_win <= 1'b1;
    end else if (w_hold_exp) begin
      r_hold_win <= 1'b0;
    end
  end
`else
  assign w_hold_blk = 1'b0;
`endif

  // control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= OFF;
      r_power <= 1'b0;
      r_chan  <= 7'(CH_MIN);
      r_vol   <= 6'(VOL_INIT);
      r_mute  <= 1'b0;
      r_pend  <= 1'b0;
      r_cmd   <= 1'b0;
      r_digit <= '0;
    end else begin
      r_cmd <= 1'b0;
      unique case (r_state)
        OFF: begin
          if (w_go && r_key == KEY_POWER) begin
            r_state <= IDLE;
            r_power <= 1'b1;
            r_cmd   <= 1'b1;
          end
        end
        default: begin
          if (w_go && w_known) begin
            r_cmd   <= 1'b1;
            r_state <= IDLE;
            r_pend  <= 1'b0;
            if (w_is_dig) begin
              if (r_state == IDLE) begin
                r_digit <= r_key[3:0];
                r_state <= DIGIT1;
                r_pend  <= 1'b1;
              end else if (w_two_ok) begin
                r_chan <= w_two;
              end
            end else begin
              case (r_key)
                KEY_CH_UP:
                  r_chan <= (r_chan >= 7'(CH_MAX)) ? 7'(CH_MIN)
                                                   : r_chan + 7'd1;
                KEY_CH_DOWN:
                  r_chan <= (r_chan <= 7'(CH_MIN)) ? 7'(CH_MAX)
                                                   : r_chan - 7'd1;
                KEY_VOL_UP: begin
                  r_vol  <= (r_vol >= 6'(VOL_MAX)) ? 6'(VOL_MAX)
                                                   : r_vol + 6'd1;
                  r_mute <= 1'b0;
                end
                KEY_VOL_DOWN: begin
                  r_vol  <= (r_vol == 6'd0) ? 6'd0 : r_vol - 6'd1;
                  r_mute <= 1'b0;
                end
                KEY_MUTE:
                  r_mute <= ~r_mute;
                KEY_POWER: begin
                  r_state <= OFF;
                  r_power <= 1'b0;
                end
                default: ;
              endcase
            end
          end else if (r_state == DIGIT1 && w_dig_exp) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
            if (w_one_ok) r_chan <= w_one;
          end
        end
      endcase
    end
  end

  assign power_on      = r_power;
  assign channel       = r_chan;
  assign volume        = r_vol;
  assign mute          = r_mute;
  assign digit_pending = r_pend;
  assign cmd_valid     = r_cmd;

endmodule

// File: tb/tb_tv_command_unit.sv
// Scoreboard bench for tv_command_unit: stimulus pushes expected state,
// a negedge monitor pops and compares on every cmd_valid pulse.
module tb_tv_command_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] remote_key = '0;
  logic       power_on;
  logic [6:0] channel;
  logic [5:0] volume;
  logic       mute;
  logic       digit_pending;
  logic       cmd_valid;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] sb_q[$];

  tv_command_unit #(
    .CH_MIN(1), .CH_MAX(99), .VOL_MAX(63), .VOL_INIT(16),
    .DIGIT_TIMEOUT(20), .HOLDOFF_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .remote_key(remote_key),
    .power_on(power_on), .channel(channel), .volume(volume),
    .mute(mute), .digit_pending(digit_pending), .cmd_valid(cmd_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pk(logic pw, logic [6:0] ch,
                                     logic [5:0] vol, logic mu, logic pd);
    return {pw, ch, vol, mu, pd};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every cmd_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && cmd_valid) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_cmd: got state %0h expected no cmd_valid",
                 pk(power_on, channel, volume, mute, digit_pending));
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        if (pk(power_on, channel, volume, mute, digit_pending) != e) begin
          n_fail++;
          $display("FAIL cmd_state: got %0h expected %0h",
                   pk(power_on, channel, volume, mute, digit_pending), e);
        end
      end
    end
  end

  task automatic send(input logic [7:0] k, input bit exp,
                      input logic [15:0] st, input int gap);
    if (exp) sb_q.push_back(st);
    @(posedge clk); #1;
    ready = 1'b1;
    remote_key = k;
    @(posedge clk); #1;
    ready = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int v;

  initial begin
    idle(2);
    reset = 1'b0;
    idle(2);
    chk("reset_state", pk(power_on, channel, volume, mute, digit_pending),
        pk(0, 1, 16, 0, 0));
    chk("reset_cmd", cmd_valid, 0);

    send(8'h20, 0, 0, 3);
    chk("off_vol", volume, 16);
    chk("off_pwr", power_on, 0);

    send(8'h40, 1, pk(1, 1, 16, 0, 0), 3);
    send(8'h04, 1, pk(1, 1, 16, 0, 1), 3);
    chk("pend_between", digit_pending, 1);
    send(8'h02, 1, pk(1, 42, 16, 0, 0), 3);
    chk("ch_42", channel, 42);

    send(8'h07, 1, pk(1, 42, 16, 0, 1), 3);
    idle(25);
    chk("timeout_ch7", channel, 7);
    chk("timeout_pend", digit_pending, 0);

    send(8'h09, 1, pk(1, 7, 16, 0, 1), 3);
    send(8'h09, 1, pk(1, 99, 16, 0, 0), 3);
    send(8'h10, 1, pk(1, 1, 16, 0, 0), 3);
    send(8'h11, 1, pk(1, 99, 16, 0, 0), 3);
    send(8'h10, 1, pk(1, 1, 16, 0, 0), 10);

    for (int i = 1; i <= 50; i++) begin
      v = (16 + i > 63) ? 63 : 16 + i;
      send(8'h20, 1, pk(1, 1, 6'(v), 0, 0), 10);
    end
    chk("vol_sat", volume, 63);
    send(8'h30, 1, pk(1, 1, 63, 1, 0), 3);
    send(8'h21, 1, pk(1, 1, 62, 0, 0), 3);

    send(8'h00, 1, pk(1, 1, 62, 0, 1), 3);
    send(8'h00, 1, pk(1, 1, 62, 0, 0), 3);
    chk("ch_00_kept", channel, 1);

    send(8'h05, 1, pk(1, 1, 62, 0, 1), 3);
    send(8'h30, 1, pk(1, 1, 62, 1, 0), 3);
    idle(25);
    chk("discard_d", channel, 1);

    send(8'h00, 1, pk(1, 1, 62, 1, 1), 3);
    idle(25);
    chk("timeout_0_kept", channel, 1);
    chk("timeout_0_pend", digit_pending, 0);

    // second digit processed on the very cycle the timer expires
    send(8'h03, 1, pk(1, 1, 62, 1, 1), 18);
    send(8'h07, 1, pk(1, 37, 62, 1, 0), 25);
    chk("race_ch37", channel, 37);

    send(8'h55, 0, 0, 3);
    send(8'h12, 0, 0, 3);

    send(8'h40, 1, pk(0, 37, 62, 1, 0), 3);
    send(8'h20, 0, 0, 3);
    send(8'h30, 0, 0, 3);
    send(8'h04, 0, 0, 3);
    chk("off_retain", pk(power_on, channel, volume, mute, digit_pending),
        pk(0, 37, 62, 1, 0));
    send(8'h40, 1, pk(1, 37, 62, 1, 0), 20);

    // VOL_DOWN pair 4 cycles apart
    send(8'h21, 1, pk(1, 37, 61, 0, 0), 2);
`ifdef REMOTE_HOLDOFF_EN
    send(8'h21, 0, 0, 20);
    v = 61;
`else
    send(8'h21, 1, pk(1, 37, 60, 0, 0), 20);
    v = 60;
`endif
    chk("pair4_vol", volume, v);

    // VOL_DOWN pair 12 cycles apart
    send(8'h21, 1, pk(1, 37, 6'(v - 1), 0, 0), 10);
    send(8'h21, 1, pk(1, 37, 6'(v - 2), 0, 0), 20);
    chk("pair12_vol", volume, v - 2);

    // ready held high for 30 cycles
    sb_q.push_back(pk(1, 37, 6'(v - 1), 0, 0));
    @(posedge clk); #1;
    ready = 1'b1;
    remote_key = 8'h20;
    repeat (30) @(posedge clk);
    #1;
    ready = 1'b0;
    idle(20);
    chk("hold_vol", volume, v - 1);

    // reset during digit entry
    send(8'h06, 1, pk(1, 37, 6'(v - 1), 0, 1), 3);
    reset = 1'b1;
    #1;
    chk("mid_reset", pk(power_on, channel, volume, mute, digit_pending),
        pk(0, 1, 16, 0, 0));
    chk("mid_reset_cmd", cmd_valid, 0);
    idle(2);
    reset = 1'b0;
    idle(25);
    chk("post_reset_ch", channel, 1);

    // POWER pair 4 cycles apart
    send(8'h40, 1, pk(1, 1, 16, 0, 0), 20);
    send(8'h40, 1, pk(0, 1, 16, 0, 0), 2);
`ifdef REMOTE_HOLDOFF_EN
    send(8'h40, 0, 0, 20);
    chk("pwr_pair", power_on, 0);
`else
    send(8'h40, 1, pk(1, 1, 16, 0, 0), 20);
    chk("pwr_pair", power_on, 1);
`endif

    idle(5);
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
